// File: rtl/csa_pkg.sv
// csa_pkg: shared sizing constants and controller state encoding for the CSA accumulator.
package csa_pkg;
  localparam int W       = 8;
  localparam int CNT_W   = 4;
  localparam int ACC_W   = W + CNT_W;
  localparam int CHUNK   = 4;
  localparam int RES_CYC = ACC_W / CHUNK;
  localparam int K_W     = $clog2(RES_CYC);
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_e;
endpackage

// File: rtl/csa_compress_row.sv
// csa_compress_row: N-wide 3:2 compressor; carry is pre-shifted left with the MSB carry dropped.
module csa_compress_row
  import csa_pkg::*;
#(
  parameter int N = ACC_W
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);
  logic [N-2:0] co;
  genvar i;
  generate
    for (i = 0; i < N - 1; i++) begin : g_fa
      full_adder u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .ci_i(c_i[i]), .s_o(sum_o[i]), .co_o(co[i]));
    end
  endgenerate
  // The top bit's carry would shift out of the row, so only its sum is formed.
  assign sum_o[N-1] = a_i[N-1] ^ b_i[N-1] ^ c_i[N-1];
  assign carry_o    = {co, 1'b0};
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: folds a counted operand stream into carry-save registers, then resolves
// sum+carry chunk by chunk and hands the binary result downstream.
module csa_accum_ctrl
  import csa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] op_count,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);
  state_e             state_q;
  logic [ACC_W-1:0]   s_q, c_q, res_q, x, s_n, c_n;
  logic [CNT_W-1:0]   rem_q;
  logic [K_W-1:0]     k_q;
  logic               cy_q, res_valid_q;
  logic [CHUNK-1:0]   ca, cb, csum;
  logic [CHUNK:0]     cc;
  assign x         = ACC_W'(in_data);
  assign in_ready  = state_q == ACCUM;
  assign busy      = state_q != IDLE;
  assign res_data  = res_q;
  assign res_valid = res_valid_q;
  csa_compress_row #(.N(ACC_W)) u_row (.a_i(s_q), .b_i(c_q), .c_i(x), .sum_o(s_n), .carry_o(c_n));
  assign ca    = s_q[k_q*CHUNK +: CHUNK];
  assign cb    = c_q[k_q*CHUNK +: CHUNK];
  assign cc[0] = cy_q;
  genvar i;
  generate
    for (i = 0; i < CHUNK; i++) begin : g_chunk
      full_adder u_fa (.a_i(ca[i]), .b_i(cb[i]), .ci_i(cc[i]), .s_o(csum[i]), .co_o(cc[i+1]));
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      rem_q       <= '0;
      k_q         <= '0;
      cy_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (op_count != '0) begin
            s_q     <= '0;
            c_q     <= '0;
            rem_q   <= op_count;
            state_q <= ACCUM;
          end else begin
            res_q       <= '0;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        ACCUM: if (in_valid) begin
          s_q   <= s_n;
          c_q   <= c_n;
          rem_q <= rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_q <= RESOLVE;
            k_q     <= '0;
            cy_q    <= 1'b0;
          end
        end
        RESOLVE: begin
          res_q[k_q*CHUNK +: CHUNK] <= csum;
          cy_q <= cc[CHUNK];
          k_q  <= k_q + 1'b1;
          if (k_q == K_W'(RES_CYC - 1)) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: if (res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: directed checks of accumulate, resolve latency, backpressure, reset and start filtering.
module tb_csa_accum_ctrl;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, res_ready = 0;
  logic [3:0]  op_count = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, res_valid, busy;
  logic [11:0] res_data;
  int checks = 0, errors = 0;

  csa_accum_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_count(op_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [3:0] n);
    start = 1; op_count = n;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 0;
      @(negedge clk);
      chk("stall_ready", in_ready, 1);
    end
    in_valid = 1; in_data = d;
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic result(input int lat, input logic [11:0] exp);
    int n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    chk("res_data", res_data, exp);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("res_valid_drop", res_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_data", res_data, 0);
    rst_n = 1;
    @(negedge clk);

    // basic run: 1+2+3
    go(3);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    chk("basic_ready_off", in_ready, 0);
    chk("basic_busy", busy, 1);
    result(3, 12'h006);

    // maximum run: 15 x 0xFF
    go(15);
    for (int i = 0; i < 15; i++) send(8'hFF, 0);
    result(3, 12'hEF1);

    // zero operands
    go(0);
    chk("zero_ready", in_ready, 0);
    result(0, 12'h000);

    // input gaps and result backpressure
    go(4);
    send(8'h10, 2); send(8'h20, 2); send(8'h30, 2); send(8'h40, 2);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 12'h0A0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    result(0, 12'h0A0);

    // reset mid-accumulation
    go(5);
    send(8'h33, 0); send(8'h44, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    go(2);
    send(8'h05, 0); send(8'h07, 0);
    result(3, 12'h00C);

    // start held high while busy, with a changed op_count
    go(2);
    start = 1; op_count = 0;
    send(8'h11, 0); send(8'h22, 0);
    chk("sb_resolve_busy", busy, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("sb_done_valid", res_valid, 1);
      chk("sb_done_data", res_data, 12'h033);
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0; start = 0;
    chk("sb_hs_idle", busy, 0);
    chk("sb_hs_valid", res_valid, 0);
    repeat (2) @(negedge clk);
    chk("sb_still_idle", busy, 0);
    chk("sb_held_data", res_data, 12'h033);
    go(1);
    send(8'h09, 0);
    result(3, 12'h009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
Sequencing controller for the carry-save adder datapath. It accepts a counted stream of W-bit operands over a valid/ready handshake and folds one operand per cycle into redundant sum/carry registers using a 3:2 compressor row. After the last operand, it resolves sum+carry into binary with a chunked ripple-carry pass over several cycles. It then presents the result over a valid/ready handshake to the downstream block.

Parameters:
W, 8, operand width in bits
CNT_W, 4, width of op_count; MAX_OPS = 2^CNT_W - 1 = 15
ACC_W, W+CNT_W (12), accumulator and result width; sized so a full run cannot overflow
CHUNK, 4, bits resolved per cycle; must divide ACC_W; RES_CYC = ACC_W/CHUNK (3)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a run; sampled only in IDLE
op_count  in  CNT_W  number of operands in the run, sampled with start
in_data  in  W  operand, zero-extended to ACC_W
in_valid  in  1  operand valid
in_ready  out  1  controller can accept an operand
res_data  out  ACC_W  resolved sum
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; S, C, res_data, chunk index, carry flop and op counter all cleared to 0; in_ready=0, res_valid=0, busy=0. Reset mid-run aborts the run with no partial result.
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - start=1 and op_count>0: clear S and C, load remaining=op_count, go to ACCUM.
  - start=1 and op_count=0: clear res_data, go to DONE.
  - start=0: stay in IDLE.
- ACCUM:
  - in_ready=1 combinationally, and only in this state.
  - Transfer occurs on in_valid & in_ready at the clock edge.
  - On each transfer, with X = zero-extended in_data:
    - S <= S^C^X
    - C <= ((S&C)|(S&X)|(C&X)) << 1, truncated to ACC_W; the MSB carry is dropped.
  - remaining decrements on each transfer. The transfer with remaining=1 moves the state to RESOLVE, with chunk index=0 and carry flop=0.
  - in_valid gaps stall the block with no state change.
- RESOLVE:
  - Each cycle, chunk k computes {cy, res_data[k*CHUNK +: CHUNK]} = S[chunk k] + C[chunk k] + carry flop, then carry flop <= cy.
  - After chunk RES_CYC-1, go to DONE; the final cy is discarded.
  - Exactly RES_CYC cycles. res_valid rises RES_CYC cycles after the edge that accepted the last operand.
- DONE:
  - res_valid=1 and res_data is held stable until res_valid & res_ready; then go to IDLE.
  - A start in the same cycle as the result handshake is ignored; it must be re-asserted in IDLE.
- start outside IDLE is ignored. op_count is not re-sampled mid-run.
- Outputs are registered except in_ready and busy, which are decoded from state.

Decomposition:
- Shared package csa_pkg:
  - state enum (IDLE, ACCUM, RESOLVE, DONE)
  - default constants W, CNT_W, ACC_W, CHUNK, RES_CYC
- One sub-module, csa_compress_row (ACC_W-wide 3:2 compressor, combinational, outputs sum and shifted carry), built from full_adder instances.
- The chunk adder is a CHUNK-bit ripple chain of existing full_adder cells inline in the controller.

Test Plan:
- Basic run: start, op_count=3; operands 8'h01, 8'h02, 8'h03 streamed back-to-back -> in_ready high for exactly 3 accepts; res_valid 3 cycles after the last accept; res_data=12'h006.
- Maximum run: op_count=15, all operands 8'hFF -> res_data=12'hEF1 (3825); no overflow; carry-out discarded.
- Zero operands: start with op_count=0 -> in_ready never high; res_valid high the cycle after start; res_data=12'h000.
- Backpressure:
  - op_count=4 (8'h10, 8'h20, 8'h30, 8'h40) with 2-cycle in_valid gaps -> res_data=12'h0A0.
  - res_ready held low for 5 cycles -> res_valid and res_data stable; busy=1 until the handshake.
- Reset mid-ACCUM: rst_n pulled low after 2 of 5 operands -> all outputs 0 immediately (async); a new run of 8'h05, 8'h07 -> 12'h00C with no residue from the aborted run.
- Start while busy: start pulses in ACCUM, RESOLVE, DONE and on the result-handshake cycle -> all ignored; the current result is unchanged and the next run begins only on a start in IDLE.
